// File: rtl/mux_arbiter_3to1.sv
// mux_arbiter_3to1: round-robin arbiter for a shared 3-to-1 resource with per-tenure transaction cap.
module mux_arbiter_3to1 #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       done_i,
  output logic [2:0] grant_o,
  output logic [1:0] select_o,
  output logic       busy_o,
  output logic [3:0] hold_cnt_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d, last_q, last_d, win;
  logic [3:0] hold_q, hold_d;
  logic [2:0] others, cand;
  logic       at_max, rel, take;
  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
  // Priority walks forward from the requester after the last grantee.
  function automatic logic [1:0] rr(input logic [2:0] m, input logic [1:0] l);
    logic [1:0] a, b;
    a = nxt(l);
    b = nxt(a);
    return m[a] ? a : (m[b] ? b : nxt(b));
  endfunction
  always_comb begin
    others  = req_i & ~grant_q;
    at_max  = hold_q == HOLD_LAST;
    rel     = !req_i[sel_q] || (done_i && at_max && |others);
    cand    = (state_q == IDLE) ? req_i : others;
    win     = rr(cand, last_q);
    take    = (state_q == IDLE) ? |req_i : (rel && |others);
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (take) begin
      state_d = GRANT;
      grant_d = 3'(1) << win;
      sel_d   = win;
      last_d  = win;
      hold_d  = '0;
    end else if (state_q == IDLE || rel) begin
      state_d = IDLE;
      grant_d = '0;
      hold_d  = '0;
    end else if (done_i) begin
      hold_d  = at_max ? 4'd0 : hold_q + 4'd1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 2'd2;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
  assign grant_o    = grant_q;
  assign select_o   = sel_q;
  assign busy_o     = state_q == GRANT;
  assign hold_cnt_o = hold_q;
endmodule

// File: tb/tb_mux_arbiter_3to1.sv
// tb_mux_arbiter_3to1: scoreboard bench with a behavioural round-robin model and random traffic.
module tb_mux_arbiter_3to1;
  localparam int HOLD_MAX = 4;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [2:0] req_i = 3'b111;
  logic       done_i = 1'b0;
  logic [2:0] grant_o;
  logic [1:0] select_o;
  logic       busy_o;
  logic [3:0] hold_cnt_o;
  typedef struct packed {
    logic [2:0] g;
    logic [1:0] s;
    logic       b;
    logic [3:0] h;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int m_g = -1, m_sel = 0, m_last = 2, m_hold = 0;
  mux_arbiter_3to1 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_o), .select_o(select_o), .busy_o(busy_o), .hold_cnt_o(hold_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic void chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got grant/sel/busy/hold=%b/%b/%b/%b expected %b/%b/%b/%b at %0t",
               name, act[9:7], act[6:5], act[4], act[3:0], exp[9:7], exp[6:5], exp[4], exp[3:0], $time);
    end
  endfunction
  function automatic int pick(input logic [2:0] m, input int l);
    for (int k = 1; k <= 3; k++)
      if (m[(l + k) % 3]) return (l + k) % 3;
    return -1;
  endfunction
  task automatic cyc(input logic rn, input logic [2:0] r, input logic d);
    int w;
    logic [2:0] oth;
    rst_i  = rn;
    req_i  = r;
    done_i = d;
    if (!rn) begin
      m_g = -1; m_sel = 0; m_last = 2; m_hold = 0;
    end else if (m_g < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin m_g = w; m_sel = w; m_last = w; m_hold = 0; end
    end else begin
      oth = r;
      oth[m_g] = 1'b0;
      if (!r[m_g] || (d && m_hold + 1 == HOLD_MAX && oth != 0)) begin
        w = pick(oth, m_last);
        m_g = w;
        m_hold = 0;
        if (w >= 0) begin m_sel = w; m_last = w; end
      end else begin
        m_hold = (m_hold + int'(d)) % HOLD_MAX;
      end
    end
    q.push_back('{g: (m_g < 0) ? 3'b000 : 3'(1 << m_g), s: 2'(m_sel), b: m_g >= 0, h: 4'(m_hold)});
    @(posedge clk_i);
    #2;
  endtask
  initial forever begin
    @(posedge clk_i);
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("outputs", {grant_o, select_o, busy_o, hold_cnt_o}, mon_e);
      if (busy_o) chk("onehot_sel", {grant_o, select_o, busy_o, hold_cnt_o},
                      {3'(1 << select_o), select_o, busy_o, hold_cnt_o});
    end
  end
  initial begin
    logic [2:0] r;
    logic       rn, d;
    #1;
    chk("reset_async", {grant_o, select_o, busy_o, hold_cnt_o}, 10'b0);
    cyc(0, 3'b111, 0);
    cyc(0, 3'b111, 0);
    cyc(1, 3'b111, 0);
    cyc(1, 3'b000, 0);
    cyc(1, 3'b010, 0);
    cyc(1, 3'b010, 1);
    cyc(1, 3'b000, 0);
    cyc(1, 3'b000, 1);
    cyc(1, 3'b111, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 3'b111, 1);
      cyc(1, 3'b111 & ~grant_o, 0);
    end
    cyc(0, 3'b000, 0);
    cyc(1, 3'b011, 0);
    repeat (6) cyc(1, 3'b011, 1);
    cyc(0, 3'b000, 0);
    cyc(1, 3'b001, 0);
    repeat (6) cyc(1, 3'b001, 1);
    cyc(0, 3'b000, 0);
    cyc(1, 3'b100, 0);
    cyc(1, 3'b100, 1);
    cyc(1, 3'b100, 1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("reset_mid_grant", {grant_o, select_o, busy_o, hold_cnt_o}, 10'b0);
    #1;
    cyc(0, 3'b101, 0);
    cyc(1, 3'b101, 0);
    r = 3'b111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 4 == 0) r ^= 3'($urandom_range(1, 7));
      d  = 1'($urandom % 2);
      rn = ($urandom % 200) != 0;
      cyc(rn, r, d);
    end
    cyc(1, 3'b000, 0);
    #5;
    chk("scoreboard_drained", 10'(q.size()), 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arbiter_3to1.md
Name: mux_arbiter_3to1

Overview:
- Round-robin arbiter that shares one downstream resource (memory port / write-back bus) among three requesters.
- Drives the 2-bit select of the shared 3-to-1 data mux and issues one-hot grants.
- Tracks completed transactions per tenure and preempts a requester after HOLD_MAX transactions when others are waiting.
- Pure control block; the data mux stays external.

Parameters:
- HOLD_MAX, 4, max transactions (done_i pulses) per tenure when another requester is pending; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- req_i  input  3  request per requester, bit k = requester k; level-sensitive, held until served
- done_i  input  1  resource completed one transaction for current grantee this cycle
- grant_o  output  3  one-hot grant, registered; 000 when idle
- select_o  output  2  mux select: 0/1/2 = requester index; holds last grantee when idle
- busy_o  output  1  1 while in GRANT state
- hold_cnt_o  output  4  transactions completed in current tenure

Behaviour:
- Reset (rst_i=0, async): state=IDLE, grant_o=000, select_o=0, busy_o=0, hold_cnt_o=0, last pointer=2 (requester 0 has top priority first).
- All outputs registered. No combinational path from inputs to outputs.
- Round-robin order: search starts at (last+1) mod 3, then wraps. last updates to the new grantee on every grant.
- IDLE:
  - if req_i != 0, next edge: state=GRANT, grant_o=onehot(winner), select_o=winner, busy_o=1, hold_cnt_o=0. Grant latency is 1 cycle from req.
  - else stay IDLE; grant_o=000; select_o holds.
- GRANT (grantee g):
  - done_i=1 -> hold_cnt_o+1 at the edge.
  - Release condition, evaluated at the edge:
    - (a) req_i[g]=0, or
    - (b) done_i=1 and hold_cnt_o==HOLD_MAX-1 and some other req_i bit=1.
  - On release with another request pending (excluding g), pick the next winner by round-robin. The new grant appears at the same edge: back-to-back, no idle bubble, hold_cnt_o=0.
  - On release with no other request pending, go to IDLE: grant_o=000, busy_o=0, hold_cnt_o=0.
  - When hold_cnt_o would reach HOLD_MAX and no other request is pending, keep the grant and wrap hold_cnt_o to 0.
  - A done_i arriving in the same cycle as req_i[g] falling is counted but irrelevant, since the counter clears on release.
- done_i in IDLE: ignored.
- Requester k asserting while not granted: waits. Worst-case wait is 2*HOLD_MAX transactions plus 2 cycles, provided requesters drop req after being served.
- grant_o is always one-hot or zero. select_o always equals the index of the set grant_o bit when busy_o=1.
- rst_i low mid-tenure: immediate return to reset values, including last pointer; no transaction is completed.

Test Plan:
- Reset: rst_i=0 with req_i=111 -> grant_o=000, select_o=0, busy_o=0. Release rst_i, hold req_i=111 -> next edge grant_o=001, select_o=0.
- Single requester: req_i=010 -> after 1 cycle grant_o=010, select_o=1. Drop req -> next edge grant_o=000, busy_o=0, select_o stays 1.
- Round robin: req_i=111 held, each requester drops after 1 done_i and reasserts -> grant sequence 001,010,100,001 with no idle cycles.
- Preemption: HOLD_MAX=4, req_i=011 held, done_i every cycle -> requester 0 is granted for 4 dones (hold_cnt_o 0..3), then grant_o=010 on the 4th done edge.
- No preemption: HOLD_MAX=4, only req_i=001, 6 dones -> grant_o stays 001, hold_cnt_o goes 0,1,2,3,0,1.
- Async reset mid-grant: grant_o=100, hold_cnt_o=2, pull rst_i low between clock edges -> outputs clear immediately. After release with req_i=101 -> grant_o=001.
